// File: rtl/ram_loader.sv
// Byte-stream program loader and idle-time CPU read front-end for the on-chip RAM.
// Optional running byte checksum is compiled in when RAM_LOADER_CHECKSUM_EN is defined.
module ram_loader #(
    parameter int DEPTH = 10,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic [DEPTH-1:0] load_base,
    input  logic [DEPTH:0]   load_count,
    input  logic             byte_valid,
    input  logic [WIDTH-1:0] byte_data,
    output logic             byte_ready,
    input  logic             cpu_req,
    input  logic [DEPTH-1:0] cpu_addr,
    output logic             cpu_ready,
    output logic             cpu_rvalid,
    output logic [31:0]      cpu_rdata,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_data,
    output logic [DEPTH-1:0] ram_addr,
    input  logic [31:0]      ram_rdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] checksum
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [DEPTH-1:0] wr_ptr_r;
    logic [DEPTH:0]   remaining_r;
    logic             done_r;
    logic             cpu_rvalid_r;
    logic             start_s;
    logic             start_nz_s;
    logic             xfer_s;
    logic             rd_acc_s;
    logic             cpu_ready_s;
    logic             byte_ready_s;

    // Handshake qualifiers; cpu_ready is gated by rst_n so nothing is accepted while held in reset.
    always_comb begin
        start_s      = (state_r == ST_IDLE) && load_start;
        start_nz_s   = start_s && (load_count != '0);
        byte_ready_s = (state_r == ST_LOAD);
        xfer_s       = byte_ready_s && byte_valid;
        cpu_ready_s  = rst_n && (state_r == ST_IDLE) && !load_start;
        rd_acc_s     = cpu_req && cpu_ready_s;
    end

    // Next-state logic for the load session.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_nz_s) begin
                    state_s = ST_LOAD;
                end else if (start_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (xfer_s && (remaining_r == (DEPTH+1)'(1))) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // RAM pin drive: a byte transfer owns the pins, else an accepted read, else park on wr_ptr.
    always_comb begin
        ram_we   = 1'b0;
        ram_data = '0;
        ram_addr = wr_ptr_r;
        if (xfer_s) begin
            ram_we   = 1'b1;
            ram_data = byte_data;
            ram_addr = wr_ptr_r;
        end else if (rd_acc_s) begin
            ram_addr = cpu_addr;
        end else begin
            ram_addr = wr_ptr_r;
        end
    end

    // State register and session bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            wr_ptr_r     <= '0;
            remaining_r  <= '0;
            done_r       <= 1'b0;
            cpu_rvalid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            done_r       <= (state_s == ST_DONE);
            cpu_rvalid_r <= rd_acc_s;
            if (start_nz_s) begin
                wr_ptr_r    <= load_base;
                remaining_r <= load_count;
            end else if (xfer_s) begin
                wr_ptr_r    <= wr_ptr_r + DEPTH'(1);
                remaining_r <= remaining_r - (DEPTH+1)'(1);
            end
        end
    end

`ifdef RAM_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] checksum_r;

    function automatic logic [WIDTH-1:0] sum_add(input logic [WIDTH-1:0] acc,
                                                 input logic [WIDTH-1:0] val);
        return acc + val;
    endfunction

    // Running modulo-2**WIDTH byte sum; a zero-length start still clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_r <= '0;
        end else if (start_s) begin
            checksum_r <= '0;
        end else if (xfer_s) begin
            checksum_r <= sum_add(checksum_r, byte_data);
        end
    end

    assign checksum = checksum_r;
`else
    assign checksum = '0;
`endif

    assign byte_ready = byte_ready_s;
    assign cpu_ready  = cpu_ready_s;
    assign cpu_rvalid = cpu_rvalid_r;
    assign cpu_rdata  = ram_rdata;
    assign busy       = (state_r != ST_IDLE);
    assign done       = done_r;

endmodule

// File: doc/ram_loader.md
# ram_loader

Program loader and read front-end for the on-chip `RAM` stage (DEPTH=10, WIDTH=8). It sits directly upstream of the RAM and is the only block that drives the RAM's `write_enable`/`data`/`address` pins. It accepts a byte stream over a valid/ready handshake and writes it to consecutive RAM words from a latched base address. When idle, it forwards CPU word reads to the RAM and returns the RAM's registered 32-bit read data with a one-cycle valid.

## Interface
Parameters:
- `DEPTH`, 10, RAM address width; RAM holds 2**DEPTH words
- `WIDTH`, 8, byte width written per word (zero-extended to 32 by RAM)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `load_start`  in  1  begin load session; sampled only in IDLE
- `load_base`  in  DEPTH  first RAM address; latched on accepted `load_start`
- `load_count`  in  DEPTH+1  number of bytes to load (0..2**DEPTH); latched with `load_start`
- `byte_valid`  in  1  upstream byte present
- `byte_data`  in  WIDTH  byte payload
- `byte_ready`  out  1  loader accepts byte this cycle
- `cpu_req`  in  1  read request
- `cpu_addr`  in  DEPTH  read word address
- `cpu_ready`  out  1  read request accepted this cycle
- `cpu_rvalid`  out  1  `cpu_rdata` valid
- `cpu_rdata`  out  32  read data
- `ram_we`  out  1  to RAM `write_enable`
- `ram_data`  out  WIDTH  to RAM `data`
- `ram_addr`  out  DEPTH  to RAM `address`
- `ram_rdata`  in  32  from RAM `data_out`
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse, load finished
- `checksum`  out  WIDTH  running byte sum (see Configuration)

## Operation
- States: IDLE, LOAD, DONE.
- IDLE:
  - `load_start`=1 with `load_count`!=0: latch `wr_ptr`<=`load_base`, `remaining`<=`load_count`, clear `checksum`, go to LOAD.
  - `load_start`=1 with `load_count`=0: go straight to DONE; no writes occur.
- LOAD:
  - `byte_ready`=1.
  - Transfer when `byte_valid & byte_ready`: `ram_we`=1, `ram_addr`=`wr_ptr`, `ram_data`=`byte_data` (combinational, same cycle).
  - On each transfer: `wr_ptr` increments modulo 2**DEPTH (1023 wraps to 0), and `remaining` decrements.
  - Transfer with `remaining`=1: go to DONE.
  - `load_start` is ignored in LOAD.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Reads:
  - `cpu_ready` = (state==IDLE) & !`load_start`. A load start wins over a same-cycle `cpu_req`, which is not accepted.
  - When `cpu_req & cpu_ready`: `ram_addr`=`cpu_addr`, `ram_we`=0.
  - `cpu_rvalid` is registered from (`cpu_req & cpu_ready`).
  - `cpu_rdata` = `ram_rdata` (pass-through); holds the last read while the RAM is not re-read.
- Default RAM drive when no transfer and no accepted read: `ram_we`=0, `ram_addr`=`wr_ptr`, `ram_data`=0.
- Reset (async, any time):
  - State IDLE; `wr_ptr`, `remaining`, `checksum`, `cpu_rvalid`, `done` = 0.
  - `byte_ready`, `cpu_ready`, `ram_we` = 0 while `rst_n`=0.
  - Reset mid-load aborts with no `done` pulse. Bytes already written stay in RAM.

## Timing
- Write: byte accepted at edge N is written into RAM at edge N (`ram_we` is combinational in the accept cycle). Throughput is 1 byte/cycle.
- Read latency: request accepted at edge N; RAM registers at edge N; `cpu_rvalid`=1 and `cpu_rdata` valid in cycle N+1. Back-to-back reads give 1 word/cycle.
- Last byte at edge N: `done`=1 in cycle N+1; `busy` falls and `cpu_ready` may rise in cycle N+2.
- Zero-length load: `load_start` at edge N gives `done` in cycle N+1.
- `byte_valid` may drop mid-load; the loader waits indefinitely and has no timeout.

## Configuration
- `RAM_LOADER_CHECKSUM_EN` defined: `checksum` accumulates the modulo-2**WIDTH sum of all bytes transferred in the current session. It is cleared on accepted `load_start` and holds after DONE.
- Not defined: `checksum` is tied to 0 and the adder is not compiled.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles mid-stream, then release → all outputs 0, state IDLE, no `done`.
- Load base=0x3FE, count=4, bytes 0x11,0x22,0x33,0x44 back-to-back → RAM[0x3FE]=0x11, [0x3FF]=0x22, [0x000]=0x33, [0x001]=0x44 (zero-extended); `done` pulses once, the cycle after the 4th accept.
- Stall: `byte_valid` toggles 1,0,0,1 with count=2 → exactly 2 writes at consecutive addresses; `done` follows the second accept; with the macro, `checksum`=byte0+byte1 mod 256.
- Read after load: `cpu_req` addr 0x3FF → `cpu_rvalid`=1 next cycle with `cpu_rdata`=0x00000022. Back-to-back reads of 0x000 then 0x001 → 0x33 then 0x44 on consecutive cycles.
- Collision: `load_start` and `cpu_req` in the same IDLE cycle → `cpu_ready`=0, no `cpu_rvalid`, load proceeds. `cpu_req` during LOAD → `cpu_ready`=0.
- Zero-length: count=0 → no `ram_we`, `done` the next cycle, `checksum`=0.
